// File: rtl/par_to_ser_pkg.sv
// Shared defaults and helpers for the multi-lane parallel-to-serial block.
package par_to_ser_pkg;

    localparam int unsigned DEF_DATA_W = 10;
    localparam logic [DEF_DATA_W-1:0] DEF_IDLE_WORD = 10'b1101010100;

    // Width of a counter that spans 0..w-1 (never narrower than one bit).
    function automatic int unsigned cnt_w(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ser_lane.sv
// One serial lane: loads a word, then shifts one bit per clock onto a p/n flop pair.
module ser_lane #(
    parameter int unsigned DATA_W    = 10,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk_5x,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    output logic              ser_p,
    output logic              ser_n
);

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              bit_nxt;

    // On load the first bit goes straight to the output flop; the remainder waits in shift_q.
    always_comb begin
        bit_nxt   = 1'b0;
        shift_nxt = shift_q;
        if (load) begin
            if (MSB_FIRST) begin
                bit_nxt   = load_word[DATA_W-1];
                shift_nxt = load_word << 1;
            end else begin
                bit_nxt   = load_word[0];
                shift_nxt = load_word >> 1;
            end
        end else begin
            if (MSB_FIRST) begin
                bit_nxt   = shift_q[DATA_W-1];
                shift_nxt = shift_q << 1;
            end else begin
                bit_nxt   = shift_q[0];
                shift_nxt = shift_q >> 1;
            end
        end
    end

    always_ff @(posedge clk_5x or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            ser_p   <= 1'b0;
            ser_n   <= 1'b1;
        end else begin
            shift_q <= shift_nxt;
            ser_p   <= bit_nxt;
            ser_n   <= ~bit_nxt;
        end
    end

endmodule

// File: rtl/par_to_ser_mc.sv
// Multi-lane serializer: one-word buffer, shared bit counter, handshake and underflow flag.
module par_to_ser_mc
    import par_to_ser_pkg::*;
#(
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter int unsigned       N_CH      = 3,
    parameter bit                MSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DEF_IDLE_WORD)
) (
    input  logic                   clk_5x,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] par_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH-1:0]        ser_data_p,
    output logic [N_CH-1:0]        ser_data_n,
    output logic                   word_start,
    output logic                   underflow,
    input  logic                   underflow_clr
);

    localparam int unsigned       CNT_W    = cnt_w(DATA_W);
    localparam int unsigned       BUS_W    = N_CH * DATA_W;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    logic [BUS_W-1:0] buf_q;
    logic [BUS_W-1:0] buf_nxt;
    logic [BUS_W-1:0] lane_words;
    logic             buf_full;
    logic             buf_full_nxt;
    logic             armed;
    logic             armed_nxt;
    logic             underflow_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic             load_c;
    logic             accept_c;

    // The buffer drains on every load edge; a same-edge accept refills it (never bypasses).
    always_comb begin
        load_c        = (bit_cnt == LAST_BIT);
        accept_c      = in_valid && in_ready;
        buf_nxt       = buf_q;
        buf_full_nxt  = buf_full;
        armed_nxt     = armed;
        underflow_nxt = underflow;
        bit_cnt_nxt   = load_c ? '0 : bit_cnt + CNT_W'(1);
        lane_words    = buf_full ? buf_q : {N_CH{IDLE_WORD}};

        if (load_c) begin
            buf_full_nxt = 1'b0;
        end
        if (accept_c) begin
            buf_nxt      = par_data;
            buf_full_nxt = 1'b1;
            armed_nxt    = 1'b1;
        end
        if (load_c && !buf_full && armed) begin
            underflow_nxt = 1'b1;
        end else if (underflow_clr) begin
            underflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_5x or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full   <= 1'b0;
            armed      <= 1'b0;
            underflow  <= 1'b0;
            bit_cnt    <= LAST_BIT;
            word_start <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            buf_q      <= buf_nxt;
            buf_full   <= buf_full_nxt;
            armed      <= armed_nxt;
            underflow  <= underflow_nxt;
            bit_cnt    <= bit_cnt_nxt;
            word_start <= load_c;
            in_ready   <= !buf_full_nxt || (bit_cnt_nxt == LAST_BIT);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        ser_lane #(
            .DATA_W    (DATA_W),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk_5x    (clk_5x),
            .rst_n     (rst_n),
            .load      (load_c),
            .load_word (lane_words[i*DATA_W +: DATA_W]),
            .ser_p     (ser_data_p[i]),
            .ser_n     (ser_data_n[i])
        );
    end

endmodule

// File: tb/tb_par_to_ser_mc.sv
// Bench for par_to_ser_mc: LSB-first and MSB-first instances checked against a word-level model.
module tb_par_to_ser_mc;

    localparam int DW  = 10;
    localparam int NC  = 3;
    localparam int BUS = NC * DW;
    localparam logic [DW-1:0] IDLE = 10'b1101010100;
    localparam logic [DW-1:0] WORD = 10'b1101001100;

    logic           clk_5x = 1'b0;
    logic           rst_n  = 1'b1;
    logic [BUS-1:0] par_data = '0;
    logic           in_valid = 1'b0;
    logic           underflow_clr = 1'b0;
    logic           rdy0, rdy1, ws0, ws1, uf0, uf1;
    logic [NC-1:0]  p0, n0, p1, n1;

    always #5 clk_5x = ~clk_5x;

    par_to_ser_mc #(.DATA_W(DW), .N_CH(NC), .MSB_FIRST(1'b0), .IDLE_WORD(IDLE)) dut0 (
        .clk_5x(clk_5x), .rst_n(rst_n), .par_data(par_data), .in_valid(in_valid),
        .in_ready(rdy0), .ser_data_p(p0), .ser_data_n(n0), .word_start(ws0),
        .underflow(uf0), .underflow_clr(underflow_clr));

    par_to_ser_mc #(.DATA_W(DW), .N_CH(NC), .MSB_FIRST(1'b1), .IDLE_WORD(IDLE)) dut1 (
        .clk_5x(clk_5x), .rst_n(rst_n), .par_data(par_data), .in_valid(in_valid),
        .in_ready(rdy1), .ser_data_p(p1), .ser_data_n(n1), .word_start(ws1),
        .underflow(uf1), .underflow_clr(underflow_clr));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Word-level reference: which word is on the lines and which bit position of it.
    logic           m_full, m_outv, m_armed, m_uf, m_ws, m_ready;
    logic [BUS-1:0] m_buf, m_cur;
    int             m_pos;

    function automatic void model_reset();
        m_full = 1'b0; m_outv = 1'b0; m_armed = 1'b0; m_uf = 1'b0;
        m_ws = 1'b0; m_ready = 1'b0; m_buf = '0; m_cur = '0; m_pos = DW - 1;
    endfunction

    function automatic void model_edge();
        logic acc;
        logic set;
        acc = in_valid && m_ready;
        set = 1'b0;
        if (m_pos == DW - 1) begin
            if (m_full) begin
                m_cur  = m_buf;
                m_full = 1'b0;
            end else begin
                m_cur = {NC{IDLE}};
                set   = m_armed;
            end
            m_pos = 0; m_ws = 1'b1; m_outv = 1'b1;
        end else begin
            m_pos++; m_ws = 1'b0;
        end
        if (acc) begin
            m_buf = par_data; m_full = 1'b1; m_armed = 1'b1;
        end
        if (set) m_uf = 1'b1;
        else if (underflow_clr) m_uf = 1'b0;
        m_ready = !m_full || (m_pos == DW - 1);
    endfunction

    function automatic logic [NC-1:0] exp_p(input logic msb);
        logic [NC-1:0] r;
        int idx;
        r   = '0;
        idx = msb ? (DW - 1 - m_pos) : m_pos;
        for (int i = 0; i < NC; i++) r[i] = m_outv && m_cur[i*DW + idx];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("p_lsb", 32'(p0), 32'(exp_p(1'b0)));
        check("n_lsb", 32'(n0), 32'(NC'(~exp_p(1'b0))));
        check("p_msb", 32'(p1), 32'(exp_p(1'b1)));
        check("n_msb", 32'(n1), 32'(NC'(~exp_p(1'b1))));
        check("ready", 32'({rdy1, rdy0}), 32'({m_ready, m_ready}));
        check("word_start", 32'({ws1, ws0}), 32'({m_ws, m_ws}));
        check("underflow", 32'({uf1, uf0}), 32'({m_uf, m_uf}));
    endtask

    task automatic step();
        @(posedge clk_5x);
        if (rst_n) model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p"}, 32'({p1, p0}), 32'(0));
        check({tag, "_n"}, 32'({n1, n0}), 32'({2*NC{1'b1}}));
        check({tag, "_ready"}, 32'({rdy1, rdy0}), 32'(0));
        check({tag, "_uf"}, 32'({uf1, uf0}), 32'(0));
        check({tag, "_ws"}, 32'({ws1, ws0}), 32'(0));
    endtask

    // Startup after release: idle word loads at once, flag stays clear.
    task automatic release_and_check(input string tag);
        @(negedge clk_5x);
        rst_n = 1'b1;
        step();
        check({tag, "_ws"}, 32'(ws0), 32'(1));
        check({tag, "_uf"}, 32'(uf0), 32'(0));
        check({tag, "_p_lsb"}, 32'(p0), 32'({NC{IDLE[0]}}));
        check({tag, "_p_msb"}, 32'(p1), 32'({NC{IDLE[DW-1]}}));
    endtask

    typedef struct {
        logic exp_lsb;
        logic exp_msb;
    } bit_vec_t;

    bit_vec_t       tbl [DW];
    logic [BUS-1:0] words [4];
    int             n, k, ws_cnt, last_ws;
    logic           was_ready;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1}; tbl[1] = '{1'b0, 1'b1}; tbl[2] = '{1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1}; tbl[4] = '{1'b0, 1'b0}; tbl[5] = '{1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1}; tbl[7] = '{1'b0, 1'b1}; tbl[8] = '{1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b0};

        // Reset values, then startup idle word.
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        step();
        step();
        release_and_check("rel");

        // Single word, serialized in both bit orders.
        par_data = {BUS'($urandom)};
        par_data[DW-1:0] = WORD;
        in_valid = 1'b1;
        n = 0;
        do begin
            was_ready = m_ready;
            step();
            n++;
        end while (!was_ready && n < 40);
        check("single_accept", 32'(was_ready), 32'(1));
        in_valid = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (ws0 !== 1'b1 && n < 40);
        check("single_ws", 32'(ws0), 32'(1));
        for (int i = 0; i < DW; i++) begin
            if (i > 0) step();
            check("single_lsb", 32'(p0[0]), 32'(tbl[i].exp_lsb));
            check("single_lsb_n", 32'(n0[0]), 32'(!tbl[i].exp_lsb));
            check("single_msb", 32'(p1[0]), 32'(tbl[i].exp_msb));
        end

        // Starvation: idle word follows and sets underflow.
        step();
        check("starve_ws", 32'(ws0), 32'(1));
        check("starve_uf", 32'(uf0), 32'(1));
        check("starve_idle", 32'(p0), 32'({NC{IDLE[0]}}));
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_clear", 32'(uf0), 32'(0));
        n = 0;
        while (m_pos != DW - 1 && n < 40) begin
            step();
            n++;
        end
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_set_wins", 32'(uf0), 32'(1));
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_clear2", 32'(uf0), 32'(0));

        // Back-to-back: four words, no idle between, word_start every DW cycles.
        for (int i = 0; i < 4; i++) words[i] = BUS'({$urandom, $urandom});
        k = 0; ws_cnt = 0; last_ws = 0; n = 0;
        in_valid = 1'b1;
        par_data = words[0];
        while (ws_cnt < 4 && n < 100) begin
            was_ready = m_ready && in_valid;
            step();
            n++;
            if (was_ready) begin
                k++;
                if (k >= 4) in_valid = 1'b0;
                else par_data = words[k];
            end
            if (ws0 === 1'b1 && k > 0 && !(k == 1 && was_ready && ws_cnt == 0 && m_cur == {NC{IDLE}})) begin
                if (ws_cnt > 0) check("b2b_gap", 32'(cyc - last_ws), 32'(DW));
                ws_cnt++;
                last_ws = cyc;
            end
        end
        check("b2b_count", 32'(ws_cnt), 32'(4));
        check("b2b_no_idle", 32'(uf0), 32'(0));
        check("b2b_last_word", 32'(p0), 32'({words[3][2*DW], words[3][DW], words[3][0]}));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            par_data      = BUS'({$urandom, $urandom});
            underflow_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        underflow_clr = 1'b0;

        // Reset in the middle of a word aborts it; startup repeats disarmed.
        in_valid = 1'b1;
        par_data = BUS'({$urandom, $urandom});
        n = 0;
        while (!(m_outv && m_pos == 4) && n < 40) begin
            step();
            n++;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        step();
        step();
        release_and_check("rel2");
        for (int i = 0; i < DW; i++) step();
        check("rel2_ws", 32'(ws0), 32'(1));
        check("rel2_disarmed", 32'({uf1, uf0}), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par_to_ser_mc.md
PAR_TO_SER_MC -- requirements
Module: par_to_ser_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 10, parallel word width per channel (>=2).
REQ-002 SHALL have parameter N_CH, default 3, number of serial lanes.
REQ-003 SHALL have parameter MSB_FIRST, default 0, bit order: 0 = bit0 first, 1 = bit DATA_W-1 first.
REQ-004 SHALL have parameter IDLE_WORD, default 10'b1101010100, word sent on every lane when no data is buffered.
REQ-005 SHALL have port clk_5x  input  1  serial bit clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port par_data  input  N_CH*DATA_W  parallel words; lane i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_valid  input  1  par_data valid.
REQ-009 SHALL have port in_ready  output  1  block can accept par_data this cycle.
REQ-010 SHALL have port ser_data_p  output  N_CH  positive serial output per lane.
REQ-011 SHALL have port ser_data_n  output  N_CH  negative serial output per lane.
REQ-012 SHALL have port word_start  output  1  high during the cycle the first bit of a word is on the lines.
REQ-013 SHALL have port underflow  output  1  sticky: an idle word was inserted after streaming started.
REQ-014 SHALL have port underflow_clr  input  1  synchronous clear of underflow.

Function
REQ-015 SHALL hold a one-entry word buffer (all lanes) plus one DATA_W-bit shift register per lane and a shared bit counter 0..DATA_W-1.
REQ-016 SHALL accept a word on a rising edge where in_valid && in_ready; in_ready = !buf_full || (bit_cnt == DATA_W-1).
REQ-017 SHALL load at the edge where bit_cnt == DATA_W-1: shift registers <= buffer if full, else IDLE_WORD on every lane; bit_cnt <= 0.
REQ-018 SHALL NOT bypass: a word accepted on a load edge enters the buffer, never the shift register on that edge.
REQ-019 SHALL, on a load edge with simultaneous accept, move old buffer to shift registers and store new word; buffer stays full.
REQ-020 SHALL on non-load edges shift each lane by one bit in the order set by MSB_FIRST and increment bit_cnt.
REQ-021 SHALL drive ser_data_p[i] directly from lane i's current output bit flop; ser_data_n = ~ser_data_p at all times outside reset.
REQ-022 SHALL emit each word in exactly DATA_W consecutive cycles, no gaps between words, first bit in the cycle after the load edge.
REQ-023 SHALL assert word_start (registered) exactly in the cycle after each load edge, including idle loads.
REQ-024 SHALL arm underflow detection on the first accepted word; an idle load while armed sets underflow.
REQ-025 SHALL clear underflow on underflow_clr; set wins when set and clear coincide.
REQ-026 SHALL keep buffered data across an underflow; streaming resumes on the next load edge with buffer full.

Reset
REQ-027 SHALL, while rst_n=0, force ser_data_p=0, ser_data_n=all ones, in_ready=0, word_start=0, underflow=0, buffer empty, detection disarmed.
REQ-028 SHALL reset bit_cnt to DATA_W-1 so the first edge after release is a load edge (loads IDLE_WORD, underflow not set).
REQ-029 SHALL abort any word in flight on reset assertion; no partial word resumes after release.

Structure
REQ-030 SHALL place default DATA_W, default IDLE_WORD and a counter-width function (clog2 of DATA_W) in shared package par_to_ser_pkg.
REQ-031 SHALL implement one lane as sub-module ser_lane (load, shift, bit order, p/n drive), instantiated N_CH times; buffer, counter, handshake, underflow stay in top.

Verification
REQ-032 SHALL check reset: rst_n=0 -> ser_data_p=000, ser_data_n=111, in_ready=0, underflow=0; release -> IDLE_WORD emitted, word_start pulses, underflow=0.
REQ-033 SHALL check single word: lane0 = 10'b11010_01100, MSB_FIRST=0 -> ser_data_p[0] = 0,0,1,1,0,0,1,0,1,1 over 10 cycles, ser_data_n[0] complementary.
REQ-034 SHALL check back-to-back: in_valid held with 4 words -> no idle between them, word_start every 10 cycles, in_ready low while buffer full except on load cycles.
REQ-035 SHALL check starvation: one word then in_valid=0 -> IDLE_WORD follows, underflow=1; underflow_clr pulse clears it; clr coinciding with idle load leaves it 1.
REQ-036 SHALL check MSB_FIRST=1 instance: 10'b11010_01100 -> 1,1,0,1,0,0,1,1,0,0.
REQ-037 SHALL check reset at bit 4 of a word -> outputs at reset values immediately; after release startup repeats (idle word, detection disarmed).
